m_stage: RTL and testbench

- Memory stage, directly downstream of the execute stage.
- Consumes the ALU result, store data and memory control from execute.
- Loads and stores run through a valid/ready data-memory port; non-memory results pass straight through.
- Produces one registered writeback packet per instruction and back-pressures execute while a memory access is outstanding.

---
 rtl/m_stage.sv | 246 ++++++++++++++++++++++++
 tb/tb_m_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_stage.sv
`default_nettype none
// ============================================================================
// Module   : m_stage
// Purpose  : Pipeline memory stage. Accepts execute packets, passes ALU
//            results straight to writeback, and runs loads/stores through a
//            valid/ready data-memory port. It emits one registered writeback
//            pulse per instruction and holds off execute while a memory
//            access is outstanding.
// Ports    : clk, rst                 - clock, async active-high reset
//            x_*                      - execute-side packet (valid/ready)
//            dmem_req_*               - data-memory request channel
//            dmem_resp_*              - data-memory load response
//            w_*                      - writeback packet (one-cycle pulse)
// Options  : MEM_MISALIGN_TRAP_EN     - when defined, a misaligned load/store
//                                       issues no request and reports
//                                       w_misalign with the faulting address.
//                                       When undefined, the offending low
//                                       address bits are ignored.
// Revision : 1.0  initial release
// ============================================================================
module m_stage #(
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [N_BITS-1:0] x_alu_out,
    input  logic [N_BITS-1:0] x_store_data,
    input  logic [1:0]        x_mem_op,
    input  logic [1:0]        x_size,
    input  logic              x_unsigned,
    input  logic [4:0]        x_rd,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [N_BITS-1:0] dmem_req_addr,
    output logic [N_BITS-1:0] dmem_req_wdata,
    output logic [3:0]        dmem_req_be,
    input  logic              dmem_resp_valid,
    input  logic [N_BITS-1:0] dmem_resp_rdata,
    output logic              w_valid,
    output logic              w_we,
    output logic [4:0]        w_rd,
    output logic [N_BITS-1:0] w_data,
    output logic              w_misalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_BITS-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [4:0]          rd_q, rd_d;
    logic                we_q, we_d;
    logic [N_BITS-1:0]   wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic                w_valid_q, w_valid_d;
    logic                w_we_q, w_we_d;
    logic [4:0]          w_rd_q, w_rd_d;
    logic [N_BITS-1:0]   w_data_q, w_data_d;
    logic                w_misalign_q, w_misalign_d;

    // Decode of the incoming packet
    logic                acc_is_mem;
    logic                acc_is_store;
    logic [3:0]          acc_be;
    logic [N_BITS-1:0]   acc_wdata;
    logic                acc_trap;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [N_BITS-1:0]   ld_data;

    assign acc_is_store = (x_mem_op == 2'b10);
    assign acc_is_mem   = (x_mem_op == 2'b01) || acc_is_store;

    // Byte enables and lane-replicated store data; size 11 behaves as word.
    always_comb begin
        acc_be    = 4'b1111;
        acc_wdata = x_store_data;
        case (x_size)
            2'b00: begin
                acc_be    = 4'b0001 << x_alu_out[1:0];
                acc_wdata = {4{x_store_data[7:0]}};
            end
            2'b01: begin
                acc_be    = x_alu_out[1] ? 4'b1100 : 4'b0011;
                acc_wdata = {2{x_store_data[15:0]}};
            end
            default: begin
                acc_be    = 4'b1111;
                acc_wdata = x_store_data;
            end
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        acc_trap = 1'b0;
        if (x_size == 2'b01) begin
            acc_trap = x_alu_out[0];
        end else if (x_size[1]) begin
            acc_trap = (x_alu_out[1:0] != 2'b00);
        end
    end
`else
    // Misaligned accesses are issued with the low bits simply ignored.
    assign acc_trap = 1'b0;
`endif

    // Load extraction from the returned word using the captured address.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = dmem_resp_rdata[7:0];
            2'b01:   ld_byte = dmem_resp_rdata[15:8];
            2'b10:   ld_byte = dmem_resp_rdata[23:16];
            default: ld_byte = dmem_resp_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? dmem_resp_rdata[31:16] : dmem_resp_rdata[15:0];
        case (size_q)
            2'b00:   ld_data = uns_q ? {{(N_BITS-8){1'b0}}, ld_byte}
                                     : {{(N_BITS-8){ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = uns_q ? {{(N_BITS-16){1'b0}}, ld_half}
                                     : {{(N_BITS-16){ld_half[15]}}, ld_half};
            default: ld_data = dmem_resp_rdata;
        endcase
    end

    // Next-state and writeback logic
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        rd_d         = rd_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        w_valid_d    = 1'b0;
        w_we_d       = 1'b0;
        w_misalign_d = 1'b0;
        w_rd_d       = w_rd_q;
        w_data_d     = w_data_q;

        case (state_q)
            S_IDLE: begin
                if (x_valid) begin
                    if (!acc_is_mem) begin
                        w_valid_d = 1'b1;
                        w_we_d    = (x_rd != 5'd0);
                        w_rd_d    = x_rd;
                        w_data_d  = x_alu_out;
                    end else if (acc_trap) begin
                        w_valid_d    = 1'b1;
                        w_misalign_d = 1'b1;
                        w_rd_d       = x_rd;
                        w_data_d     = x_alu_out;
                    end else begin
                        addr_d  = x_alu_out;
                        size_d  = x_size;
                        uns_d   = x_unsigned;
                        rd_d    = x_rd;
                        we_d    = acc_is_store;
                        wdata_d = acc_wdata;
                        be_d    = acc_be;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dmem_req_ready) begin
                    if (we_q) begin
                        // Store retires on the request handshake.
                        w_valid_d = 1'b1;
                        w_rd_d    = rd_q;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (dmem_resp_valid) begin
                    w_valid_d = 1'b1;
                    w_we_d    = (rd_q != 5'd0);
                    w_rd_d    = rd_q;
                    w_data_d  = ld_data;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            rd_q         <= 5'd0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            be_q         <= 4'b0000;
            w_valid_q    <= 1'b0;
            w_we_q       <= 1'b0;
            w_rd_q       <= 5'd0;
            w_data_q     <= '0;
            w_misalign_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            rd_q         <= rd_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            w_valid_q    <= w_valid_d;
            w_we_q       <= w_we_d;
            w_rd_q       <= w_rd_d;
            w_data_q     <= w_data_d;
            w_misalign_q <= w_misalign_d;
        end
    end

    // Request valid decodes directly from state so reset removes it at once.
    assign x_ready        = (state_q == S_IDLE);
    assign dmem_req_valid = (state_q == S_REQ);
    assign dmem_req_we    = (state_q == S_REQ) && we_q;
    assign dmem_req_addr  = {addr_q[N_BITS-1:2], 2'b00};
    assign dmem_req_wdata = wdata_q;
    assign dmem_req_be    = be_q;
    assign w_valid        = w_valid_q;
    assign w_we           = w_we_q;
    assign w_rd           = w_rd_q;
    assign w_data         = w_data_q;
    assign w_misalign     = w_misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_m_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_stage
// Purpose  : Directed self-checking bench for m_stage. Inputs are driven and
//            outputs sampled 1 time unit after each rising clock edge.
// Options  : honours MEM_MISALIGN_TRAP_EN for the misaligned-access case.
// Revision : 1.0  initial release
// ============================================================================
module tb_m_stage;

    logic        clk;
    logic        rst;
    logic        x_valid;
    logic        x_ready;
    logic [31:0] x_alu_out;
    logic [31:0] x_store_data;
    logic [1:0]  x_mem_op;
    logic [1:0]  x_size;
    logic        x_unsigned;
    logic [4:0]  x_rd;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_be;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;
    logic        w_valid;
    logic        w_we;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic        w_misalign;

    int n_checks = 0;
    int n_errors = 0;

    m_stage #(.N_BITS(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .x_valid         (x_valid),
        .x_ready         (x_ready),
        .x_alu_out       (x_alu_out),
        .x_store_data    (x_store_data),
        .x_mem_op        (x_mem_op),
        .x_size          (x_size),
        .x_unsigned      (x_unsigned),
        .x_rd            (x_rd),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_we     (dmem_req_we),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_req_be     (dmem_req_be),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_rdata (dmem_resp_rdata),
        .w_valid         (w_valid),
        .w_we            (w_we),
        .w_rd            (w_rd),
        .w_data          (w_data),
        .w_misalign      (w_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] sz,
                         input logic uns, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] sd);
        x_valid      = v;
        x_mem_op     = op;
        x_size       = sz;
        x_unsigned   = uns;
        x_rd         = rd;
        x_alu_out    = alu;
        x_store_data = sd;
    endtask

    logic [31:0] alu_data [3];
    logic [4:0]  alu_rd   [3];
    logic        alu_we   [3];

    initial begin
        alu_data[0] = 32'h11; alu_rd[0] = 5'd5; alu_we[0] = 1'b1;
        alu_data[1] = 32'h22; alu_rd[1] = 5'd6; alu_we[1] = 1'b1;
        alu_data[2] = 32'h33; alu_rd[2] = 5'd0; alu_we[2] = 1'b0;

        rst             = 1'b1;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'h0;
        drive(1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        tick();

        // Reset state
        check("rst_x_ready", x_ready, 1);
        check("rst_req_valid", dmem_req_valid, 0);
        check("rst_w_valid", w_valid, 0);
        check("rst_w_data", w_data, 0);
        check("rst_w_misalign", w_misalign, 0);
        rst = 1'b0;
        tick();

        // Response outside RESP is ignored
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'hDEADBEEF;
        tick();
        check("idle_resp_ignored", w_valid, 0);
        dmem_resp_valid = 1'b0;

        // ALU pass-through, three back-to-back packets
        drive(1'b1, 2'b00, 2'b10, 1'b0, alu_rd[0], alu_data[0], 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("alu_w_valid", w_valid, 1);
            check("alu_w_data", w_data, alu_data[i]);
            check("alu_w_rd", w_rd, alu_rd[i]);
            check("alu_w_we", w_we, alu_we[i]);
            check("alu_x_ready", x_ready, 1);
            if (i < 2) drive(1'b1, 2'b00, 2'b10, 1'b0, alu_rd[i+1], alu_data[i+1], 32'h0);
            else       drive(1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
            tick();
        end
        check("alu_idle_after", w_valid, 0);

        // Store byte at 0x1003, memory ready delayed two cycles
        drive(1'b1, 2'b10, 2'b00, 1'b0, 5'd0, 32'h0000_1003, 32'h0000_00A5);
        tick();
        drive(1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            check("stb_req_valid", dmem_req_valid, 1);
            check("stb_req_we", dmem_req_we, 1);
            check("stb_req_addr", dmem_req_addr, 32'h0000_1000);
            check("stb_req_wdata", dmem_req_wdata, 32'hA5A5_A5A5);
            check("stb_req_be", dmem_req_be, 4'b1000);
            check("stb_x_ready", x_ready, 0);
            check("stb_w_valid_wait", w_valid, 0);
            tick();
            if (i == 0) dmem_req_ready = 1'b1;
        end
        check("stb_w_valid", w_valid, 1);
        check("stb_w_we", w_we, 0);
        check("stb_req_dropped", dmem_req_valid, 0);
        check("stb_x_ready_after", x_ready, 1);
        tick();
        check("stb_single_pulse", w_valid, 0);

        // Store half at 0x12: upper lanes, replicated data
        drive(1'b1, 2'b10, 2'b01, 1'b0, 5'd0, 32'h0000_0012, 32'h1234_ABCD);
        tick();
        drive(1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
        check("sth_req_be", dmem_req_be, 4'b1100);
        check("sth_req_wdata", dmem_req_wdata, 32'hABCD_ABCD);
        check("sth_req_addr", dmem_req_addr, 32'h0000_0010);
        tick();
        check("sth_w_valid", w_valid, 1);
        check("sth_w_we", w_we, 0);
        tick();

        // Load half signed at 0x2002, response three cycles after accept
        drive(1'b1, 2'b01, 2'b01, 1'b0, 5'd7, 32'h0000_2002, 32'h0);
        tick();
        drive(1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
        check("lh_req_valid", dmem_req_valid, 1);
        check("lh_req_we", dmem_req_we, 0);
        check("lh_req_addr", dmem_req_addr, 32'h0000_2000);
        check("lh_req_be", dmem_req_be, 4'b1100);
        tick();
        check("lh_resp_req_valid", dmem_req_valid, 0);
        check("lh_resp_w_valid", w_valid, 0);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h8001_FFFF;
        tick();
        dmem_resp_valid = 1'b0;
        check("lh_w_valid", w_valid, 1);
        check("lh_w_data", w_data, 32'hFFFF_8001);
        check("lh_w_rd", w_rd, 5'd7);
        check("lh_w_we", w_we, 1);
        tick();
        check("lh_single_pulse", w_valid, 0);

        // Load half unsigned, response held off one extra cycle
        drive(1'b1, 2'b01, 2'b01, 1'b1, 5'd7, 32'h0000_2002, 32'h0);
        tick();
        drive(1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        tick();
        check("lhu_wait_w_valid", w_valid, 0);
        check("lhu_wait_x_ready", x_ready, 0);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h8001_FFFF;
        tick();
        dmem_resp_valid = 1'b0;
        check("lhu_w_valid", w_valid, 1);
        check("lhu_w_data", w_data, 32'h0000_8001);
        tick();

        // Load byte signed, lane 1
        drive(1'b1, 2'b01, 2'b00, 1'b0, 5'd2, 32'h0000_5001, 32'h0);
        tick();
        drive(1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
        check("lb_req_be", dmem_req_be, 4'b0010);
        tick();
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h0000_F700;
        tick();
        dmem_resp_valid = 1'b0;
        check("lb_w_data", w_data, 32'hFFFF_FFF7);
        tick();

        // Back-pressure: ALU packet waits behind an outstanding load
        drive(1'b1, 2'b01, 2'b10, 1'b0, 5'd9, 32'h0000_2000, 32'h0);
        tick();
        drive(1'b1, 2'b00, 2'b00, 1'b0, 5'd3, 32'h0000_0055, 32'h0);
        check("bp_x_ready_req", x_ready, 0);
        tick();
        check("bp_x_ready_resp", x_ready, 0);
        check("bp_w_valid_resp", w_valid, 0);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h1234_5678;
        tick();
        dmem_resp_valid = 1'b0;
        check("bp_ld_w_valid", w_valid, 1);
        check("bp_ld_w_data", w_data, 32'h1234_5678);
        check("bp_ld_w_rd", w_rd, 5'd9);
        check("bp_x_ready_after", x_ready, 1);
        tick();
        drive(1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
        check("bp_alu_w_valid", w_valid, 1);
        check("bp_alu_w_data", w_data, 32'h0000_0055);
        check("bp_alu_w_rd", w_rd, 5'd3);
        tick();
        check("bp_idle", w_valid, 0);

        // Async reset while a request is pending
        dmem_req_ready = 1'b0;
        drive(1'b1, 2'b01, 2'b10, 1'b0, 5'd4, 32'h0000_4000, 32'h0);
        tick();
        drive(1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
        check("rstreq_pre_valid", dmem_req_valid, 1);
        rst = 1'b1;
        #1;
        check("rstreq_req_valid", dmem_req_valid, 0);
        check("rstreq_x_ready", x_ready, 1);
        #1;
        rst = 1'b0;
        dmem_req_ready = 1'b1;

        // Async reset in RESP followed by a late response
        drive(1'b1, 2'b01, 2'b00, 1'b0, 5'd4, 32'h0000_4001, 32'h0);
        tick();
        drive(1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
        tick();
        check("rstresp_pre_x_ready", x_ready, 0);
        rst = 1'b1;
        #1;
        check("rstresp_req_valid", dmem_req_valid, 0);
        check("rstresp_x_ready", x_ready, 1);
        check("rstresp_w_valid", w_valid, 0);
        #1;
        rst = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h0000_AA00;
        tick();
        dmem_resp_valid = 1'b0;
        check("rstresp_late_w_valid", w_valid, 0);
        check("rstresp_late_x_ready", x_ready, 1);
        tick();
        check("rstresp_late_w_valid2", w_valid, 0);

        // Misaligned word load at 0x3001
        drive(1'b1, 2'b01, 2'b10, 1'b0, 5'd8, 32'h0000_3001, 32'h0);
        tick();
        drive(1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_req_valid", dmem_req_valid, 0);
        check("mis_w_valid", w_valid, 1);
        check("mis_w_misalign", w_misalign, 1);
        check("mis_w_we", w_we, 0);
        check("mis_w_data", w_data, 32'h0000_3001);
        check("mis_x_ready", x_ready, 1);
        tick();
        check("mis_w_valid_after", w_valid, 0);
        check("mis_flag_after", w_misalign, 0);
`else
        check("mis_req_valid", dmem_req_valid, 1);
        check("mis_req_addr", dmem_req_addr, 32'h0000_3000);
        check("mis_req_be", dmem_req_be, 4'b1111);
        tick();
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'hCAFE_BABE;
        tick();
        dmem_resp_valid = 1'b0;
        check("mis_w_valid", w_valid, 1);
        check("mis_w_data", w_data, 32'hCAFE_BABE);
        check("mis_w_misalign", w_misalign, 0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
